// File: rtl/hp_pkg.sv
// Shared types and constants for the two-player HP controller.
// Match state encoding, winner codes, datapath widths and the saturating damage helper.
package hp_pkg;

    localparam int HP_W  = 10;
    localparam int DMG_W = 8;
    localparam int TMR_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        KO   = 2'd2,
        OVER = 2'd3
    } game_state_t;

    typedef enum logic {
        RR_P1 = 1'b0,
        RR_P2 = 1'b1
    } rr_ptr_t;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;

    // Damage never wraps: anything at or above the current HP floors it at zero.
    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0]  hp,
                                                 input logic [DMG_W-1:0] dmg);
        logic [HP_W-1:0] dmg_ext;
        dmg_ext = {{(HP_W-DMG_W){1'b0}}, dmg};
        return (hp > dmg_ext) ? (hp - dmg_ext) : '0;
    endfunction

endpackage

// File: rtl/hp_invuln_timer.sv
// Frame-based down-counter: loads a frame count and decrements once per frame_tick.
// Used for each player's invulnerability window and for the KO countdown.
module hp_invuln_timer
    import hp_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clear,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             frame_tick,
    output logic             busy
);

    logic [TMR_W-1:0] count;

    // NOTE: reset is synchronous and active-high, so it lives inside the clocked
    // branch rather than in the sensitivity list.
    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (frame_tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/hp_controller.sv
// Match sequencer and HP owner: IDLE -> PLAY -> KO -> OVER, with a round-robin
// arbiter feeding both damage channels through one shared saturating subtractor.
module hp_controller
    import hp_pkg::*;
#(
    parameter int HP_MAX        = 200,
    parameter int INVULN_FRAMES = 30,
    parameter int KO_FRAMES     = 120
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_tick,
    input  logic             start,
    input  logic             hit1_req,
    input  logic [DMG_W-1:0] hit1_dmg,
    output logic             hit1_ack,
    input  logic             hit2_req,
    input  logic [DMG_W-1:0] hit2_dmg,
    output logic             hit2_ack,
    output logic [HP_W-1:0]  player_hp1,
    output logic [HP_W-1:0]  player_hp2,
    output logic             invuln1,
    output logic             invuln2,
    output logic [1:0]       state,
    output logic [1:0]       winner,
    output logic             game_over
);

    localparam logic [HP_W-1:0]  HP_FULL    = HP_W'(HP_MAX);
    localparam logic [TMR_W-1:0] INV_RELOAD = TMR_W'(INVULN_FRAMES);
    localparam logic [TMR_W-1:0] KO_RELOAD  = TMR_W'(KO_FRAMES);

    game_state_t     state_q, state_d;
    rr_ptr_t         ptr_q, ptr_d;
    logic [HP_W-1:0] hp1_q, hp1_d, hp2_q, hp2_d;
    logic [1:0]      winner_q, winner_d;
    logic            ack1_q, ack1_d, ack2_q, ack2_d;

    logic            req1, req2, grant1, grant2, hp_zero;
    logic            inv1_load, inv2_load, inv_clear, ko_load;
    logic            inv1_busy, inv2_busy, ko_busy;
    logic [HP_W-1:0]  sel_hp, sub_hp;
    logic [DMG_W-1:0] sel_dmg;
    logic             sel_inv;

    hp_invuln_timer u_inv1 (
        .Clk        (Clk),
        .Reset      (Reset),
        .clear      (inv_clear),
        .load       (inv1_load),
        .load_val   (INV_RELOAD),
        .frame_tick (frame_tick),
        .busy       (inv1_busy)
    );

    hp_invuln_timer u_inv2 (
        .Clk        (Clk),
        .Reset      (Reset),
        .clear      (inv_clear),
        .load       (inv2_load),
        .load_val   (INV_RELOAD),
        .frame_tick (frame_tick),
        .busy       (inv2_busy)
    );

    hp_invuln_timer u_ko (
        .Clk        (Clk),
        .Reset      (Reset),
        .clear      (1'b0),
        .load       (ko_load),
        .load_val   (KO_RELOAD),
        .frame_tick (frame_tick),
        .busy       (ko_busy)
    );

    // A request is already being acknowledged this cycle; masking it prevents a double grant.
    assign req1    = hit1_req & ~ack1_q;
    assign req2    = hit2_req & ~ack2_q;
    assign hp_zero = (hp1_q == '0) || (hp2_q == '0);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hp1_d     = hp1_q;
        hp2_d     = hp2_q;
        winner_d  = winner_q;
        ack1_d    = 1'b0;
        ack2_d    = 1'b0;
        grant1    = 1'b0;
        grant2    = 1'b0;
        inv1_load = 1'b0;
        inv2_load = 1'b0;
        inv_clear = 1'b0;
        ko_load   = 1'b0;

        case (state_q)
            IDLE: begin
                hp1_d  = HP_FULL;
                hp2_d  = HP_FULL;
                ack1_d = req1;
                ack2_d = req2;
                if (start) state_d = PLAY;
            end
            PLAY: begin
                if (hp_zero) begin
                    state_d  = KO;
                    ko_load  = 1'b1;
                    winner_d = (hp1_q == '0) ? WINNER_P2 : WINNER_P1;
                end else begin
                    if (req1 && req2) begin
                        grant1 = (ptr_q == RR_P1);
                        grant2 = (ptr_q == RR_P2);
                        ptr_d  = (ptr_q == RR_P1) ? RR_P2 : RR_P1;
                    end else begin
                        grant1 = req1;
                        grant2 = req2;
                    end
                    ack1_d = grant1;
                    ack2_d = grant2;
                end
            end
            KO: begin
                ack1_d = req1;
                ack2_d = req2;
                if (!ko_busy) state_d = OVER;
            end
            OVER: begin
                ack1_d = req1;
                ack2_d = req2;
                if (start) begin
                    state_d   = PLAY;
                    hp1_d     = HP_FULL;
                    hp2_d     = HP_FULL;
                    inv_clear = 1'b1;
                    winner_d  = WINNER_NONE;
                    ptr_d     = RR_P1;
                end
            end
            default: state_d = IDLE;
        endcase

        // One subtractor serves both players; the grant selects its operands.
        sel_hp  = grant2 ? hp2_q : hp1_q;
        sel_dmg = grant2 ? hit2_dmg : hit1_dmg;
        sel_inv = grant2 ? inv2_busy : inv1_busy;
        sub_hp  = sat_sub(sel_hp, sel_dmg);

        if ((grant1 || grant2) && !sel_inv && (sel_dmg != '0)) begin
            if (grant1) begin
                hp1_d     = sub_hp;
                inv1_load = 1'b1;
            end else begin
                hp2_d     = sub_hp;
                inv2_load = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            ptr_q    <= RR_P1;
            hp1_q    <= HP_FULL;
            hp2_q    <= HP_FULL;
            winner_q <= WINNER_NONE;
            ack1_q   <= 1'b0;
            ack2_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            hp1_q    <= hp1_d;
            hp2_q    <= hp2_d;
            winner_q <= winner_d;
            ack1_q   <= ack1_d;
            ack2_q   <= ack2_d;
        end
    end

    assign hit1_ack   = ack1_q;
    assign hit2_ack   = ack2_q;
    assign player_hp1 = hp1_q;
    assign player_hp2 = hp2_q;
    assign invuln1    = inv1_busy;
    assign invuln2    = inv2_busy;
    assign state      = state_q;
    assign winner     = winner_q;
    assign game_over  = (state_q == OVER);

endmodule

// File: tb/tb_hp_controller.sv
// Self-checking bench for hp_controller: scenario tasks plus an ack scoreboard that
// pairs every acknowledged hit with the channel and HP value expected at that moment.
module tb_hp_controller;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       hit1_req = 1'b0;
    logic [7:0] hit1_dmg = 8'd0;
    logic       hit1_ack;
    logic       hit2_req = 1'b0;
    logic [7:0] hit2_dmg = 8'd0;
    logic       hit2_ack;
    logic [9:0] player_hp1, player_hp2;
    logic       invuln1, invuln2;
    logic [1:0] state, winner;
    logic       game_over;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int         ch;
        logic [9:0] hp;
    } exp_t;

    exp_t sb[$];

    hp_controller dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .start      (start),
        .hit1_req   (hit1_req),
        .hit1_dmg   (hit1_dmg),
        .hit1_ack   (hit1_ack),
        .hit2_req   (hit2_req),
        .hit2_dmg   (hit2_dmg),
        .hit2_ack   (hit2_ack),
        .player_hp1 (player_hp1),
        .player_hp2 (player_hp2),
        .invuln1    (invuln1),
        .invuln2    (invuln2),
        .state      (state),
        .winner     (winner),
        .game_over  (game_over)
    );

    always #5 Clk = ~Clk;

    // Ack monitor: each ack pops the oldest expectation and checks channel and HP.
    exp_t       mon_e;
    logic       mon_ack;
    logic [9:0] mon_hp;
    always @(negedge Clk) begin
        for (int ch = 1; ch <= 2; ch++) begin
            mon_ack = (ch == 1) ? hit1_ack : hit2_ack;
            mon_hp  = (ch == 1) ? player_hp1 : player_hp2;
            if (mon_ack) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_spurious_ack: ack on channel %0d with nothing expected", ch);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.ch != ch || mon_hp !== mon_e.hp) begin
                        miscompares++;
                        $display("FAIL sb_ack: got ch%0d hp=%0d, want ch%0d hp=%0d",
                                 ch, mon_hp, mon_e.ch, mon_e.hp);
                    end
                end
            end
        end
        if (hit1_ack && hit2_ack && state == 2'd1) begin
            vectors++;
            miscompares++;
            $display("FAIL dual_ack_in_play: both acks high in the same PLAY cycle");
        end
    end

    function automatic exp_t mk(input int ch, input logic [9:0] hp);
        exp_t e;
        e.ch = ch;
        e.hp = hp;
        return e;
    endfunction

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk) frame_tick = 1'b1;
            @(negedge Clk) frame_tick = 1'b0;
        end
    endtask

    // Raises the chosen requests and holds each until its ack; ack latency is bounded.
    task automatic drive_hits(input bit r1, input bit r2, input logic [7:0] d1,
                              input logic [7:0] d2, input bit tick_first);
        bit p1, p2;
        int cyc;
        p1 = r1;
        p2 = r2;
        cyc = 0;
        hit1_dmg = d1;
        hit2_dmg = d2;
        hit1_req = r1;
        hit2_req = r2;
        frame_tick = tick_first;
        while ((p1 || p2) && cyc < 8) begin
            @(negedge Clk);
            cyc++;
            frame_tick = 1'b0;
            if (p1 && hit1_ack) begin
                p1 = 1'b0;
                hit1_req = 1'b0;
                vectors++;
                if (cyc > 2) begin
                    miscompares++;
                    $display("FAIL ack1_latency: got %0d cycles, want <= 2", cyc);
                end
            end
            if (p2 && hit2_ack) begin
                p2 = 1'b0;
                hit2_req = 1'b0;
                vectors++;
                if (cyc > 2) begin
                    miscompares++;
                    $display("FAIL ack2_latency: got %0d cycles, want <= 2", cyc);
                end
            end
        end
        if (p1 || p2) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_timeout: pending p1=%0d p2=%0d after %0d cycles", p1, p2, cyc);
            hit1_req = 1'b0;
            hit2_req = 1'b0;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge Clk);
        vectors++;
        if (state !== 2'd0 || game_over !== 1'b0 || winner !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_state: got state=%0d over=%0b winner=%b, want 0/0/00",
                     state, game_over, winner);
        end
        vectors++;
        if (player_hp1 !== 10'd200 || player_hp2 !== 10'd200) begin
            miscompares++;
            $display("FAIL reset_hp: got %0d/%0d, want 200/200", player_hp1, player_hp2);
        end
        vectors++;
        if (invuln1 !== 1'b0 || invuln2 !== 1'b0 || hit1_ack !== 1'b0 || hit2_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got inv=%b%b ack=%b%b, want 00/00",
                     invuln1, invuln2, hit1_ack, hit2_ack);
        end
        Reset = 1'b0;
    endtask

    task automatic test_start_hit;
        @(negedge Clk) start = 1'b1;
        @(negedge Clk);
        vectors++;
        if (state !== 2'd1) begin
            miscompares++;
            $display("FAIL start_to_play: got state=%0d, want 1", state);
        end
        start = 1'b0;
        sb.push_back(mk(1, 10'd150));
        drive_hits(1'b1, 1'b0, 8'd50, 8'd0, 1'b0);
        vectors++;
        if (invuln1 !== 1'b1 || player_hp1 !== 10'd150) begin
            miscompares++;
            $display("FAIL hit1_invuln: got inv1=%b hp1=%0d, want 1/150", invuln1, player_hp1);
        end
        ticks(29);
        vectors++;
        if (invuln1 !== 1'b1) begin
            miscompares++;
            $display("FAIL invuln1_29: got %b after 29 ticks, want 1", invuln1);
        end
        ticks(1);
        vectors++;
        if (invuln1 !== 1'b0) begin
            miscompares++;
            $display("FAIL invuln1_30: got %b after 30 ticks, want 0", invuln1);
        end
    endtask

    task automatic test_arbitration;
        // Pointer starts at P1, so P1 wins first; next contention must favour P2.
        sb.push_back(mk(1, 10'd140));
        sb.push_back(mk(2, 10'd190));
        drive_hits(1'b1, 1'b1, 8'd10, 8'd10, 1'b0);
        ticks(30);
        sb.push_back(mk(2, 10'd180));
        sb.push_back(mk(1, 10'd130));
        drive_hits(1'b1, 1'b1, 8'd10, 8'd10, 1'b0);
        vectors++;
        if (player_hp1 !== 10'd130 || player_hp2 !== 10'd180) begin
            miscompares++;
            $display("FAIL rr_hp: got %0d/%0d, want 130/180", player_hp1, player_hp2);
        end
        ticks(30);
    endtask

    task automatic test_invuln;
        sb.push_back(mk(1, 10'd110));
        drive_hits(1'b1, 1'b0, 8'd20, 8'd0, 1'b0);
        sb.push_back(mk(1, 10'd110));
        drive_hits(1'b1, 1'b0, 8'd20, 8'd0, 1'b0);
        vectors++;
        if (invuln1 !== 1'b1 || player_hp1 !== 10'd110) begin
            miscompares++;
            $display("FAIL invuln_ignore: got inv1=%b hp1=%0d, want 1/110", invuln1, player_hp1);
        end
        sb.push_back(mk(2, 10'd180));
        drive_hits(1'b0, 1'b1, 8'd0, 8'd0, 1'b0);
        vectors++;
        if (invuln2 !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_dmg_no_invuln: got inv2=%b, want 0", invuln2);
        end
        // Tick coincides with the grant edge: the load must win over the decrement.
        sb.push_back(mk(2, 10'd175));
        drive_hits(1'b0, 1'b1, 8'd0, 8'd5, 1'b1);
        ticks(29);
        vectors++;
        if (invuln2 !== 1'b1) begin
            miscompares++;
            $display("FAIL load_beats_tick: got inv2=%b after 29 ticks, want 1", invuln2);
        end
        ticks(1);
        vectors++;
        if (invuln2 !== 1'b0) begin
            miscompares++;
            $display("FAIL invuln2_expire: got %b, want 0", invuln2);
        end
    endtask

    task automatic test_ko;
        int waited;
        sb.push_back(mk(2, 10'd5));
        drive_hits(1'b0, 1'b1, 8'd0, 8'd170, 1'b0);
        ticks(30);
        sb.push_back(mk(2, 10'd0));
        drive_hits(1'b0, 1'b1, 8'd0, 8'd200, 1'b0);
        @(negedge Clk);
        vectors++;
        if (state !== 2'd2 || winner !== 2'b01 || player_hp2 !== 10'd0) begin
            miscompares++;
            $display("FAIL ko_entry: got state=%0d winner=%b hp2=%0d, want 2/01/0",
                     state, winner, player_hp2);
        end
        ticks(119);
        vectors++;
        if (state !== 2'd2) begin
            miscompares++;
            $display("FAIL ko_hold_119: got state=%0d, want 2", state);
        end
        ticks(1);
        waited = 0;
        while (!game_over && waited < 4) begin
            @(negedge Clk);
            waited++;
        end
        vectors++;
        if (game_over !== 1'b1 || state !== 2'd3 || winner !== 2'b01) begin
            miscompares++;
            $display("FAIL over_entry: got over=%b state=%0d winner=%b, want 1/3/01",
                     game_over, state, winner);
        end
        vectors++;
        if (player_hp1 !== 10'd110 || player_hp2 !== 10'd0) begin
            miscompares++;
            $display("FAIL hp_frozen: got %0d/%0d, want 110/0", player_hp1, player_hp2);
        end
        sb.push_back(mk(1, 10'd110));
        drive_hits(1'b1, 1'b0, 8'd50, 8'd0, 1'b0);
    endtask

    task automatic test_restart;
        @(negedge Clk) start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        vectors++;
        if (state !== 2'd1 || player_hp1 !== 10'd200 || player_hp2 !== 10'd200 ||
            winner !== 2'b00 || invuln1 !== 1'b0 || invuln2 !== 1'b0) begin
            miscompares++;
            $display("FAIL restart: got state=%0d hp=%0d/%0d winner=%b inv=%b%b, want 1 200/200 00 00",
                     state, player_hp1, player_hp2, winner, invuln1, invuln2);
        end
        sb.push_back(mk(1, 10'd190));
        sb.push_back(mk(2, 10'd190));
        drive_hits(1'b1, 1'b1, 8'd10, 8'd10, 1'b0);
    endtask

    task automatic test_reset_mid_ko;
        ticks(30);
        sb.push_back(mk(1, 10'd0));
        drive_hits(1'b1, 1'b0, 8'd255, 8'd0, 1'b0);
        @(negedge Clk);
        vectors++;
        if (state !== 2'd2 || winner !== 2'b10) begin
            miscompares++;
            $display("FAIL ko_p2_wins: got state=%0d winner=%b, want 2/10", state, winner);
        end
        ticks(3);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        vectors++;
        if (state !== 2'd0 || player_hp1 !== 10'd200 || player_hp2 !== 10'd200 ||
            winner !== 2'b00 || game_over !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_ko: got state=%0d hp=%0d/%0d winner=%b over=%b, want 0 200/200 00 0",
                     state, player_hp1, player_hp2, winner, game_over);
        end
    endtask

    task automatic test_idle_req;
        sb.push_back(mk(1, 10'd200));
        drive_hits(1'b1, 1'b0, 8'd50, 8'd0, 1'b0);
        @(negedge Clk);
        vectors++;
        if (state !== 2'd0 || player_hp1 !== 10'd200) begin
            miscompares++;
            $display("FAIL idle_req: got state=%0d hp1=%0d, want 0/200", state, player_hp1);
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: got %0d expectations left, want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_start_hit();
        test_arbitration();
        test_invuln();
        test_ko();
        test_restart();
        test_reset_mid_ko();
        test_idle_req();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
